// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_pkg
// Purpose  : Shared definitions for the Y86-64 fetch stage: icode values,
//            status codes, fetch FSM states and the instruction-length helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package y86_pkg;

    // Instruction codes (upper nibble of byte 0)
    localparam logic [3:0] c_I_HALT   = 4'h0;
    localparam logic [3:0] c_I_NOP    = 4'h1;
    localparam logic [3:0] c_I_RRMOVQ = 4'h2;
    localparam logic [3:0] c_I_IRMOVQ = 4'h3;
    localparam logic [3:0] c_I_RMMOVQ = 4'h4;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_OPQ    = 4'h6;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_CALL   = 4'h8;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_PUSHQ  = 4'hA;
    localparam logic [3:0] c_I_POPQ   = 4'hB;

    // Status codes
    localparam logic [2:0] c_STAT_AOK = 3'd1;
    localparam logic [2:0] c_STAT_HLT = 3'd2;
    localparam logic [2:0] c_STAT_ADR = 3'd3;
    localparam logic [2:0] c_STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERR   = 3'd5
    } fetch_state_t;

    // Encoded length in bytes. Undefined icodes count as one byte so that
    // the range check still has something sensible to work with.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            c_I_RRMOVQ, c_I_OPQ, c_I_PUSHQ, c_I_POPQ: len = 4'd2;
            c_I_JXX, c_I_CALL:                        len = 4'd9;
            c_I_IRMOVQ, c_I_RMMOVQ, c_I_MRMOVQ:       len = 4'd10;
            default:                                  len = 4'd1;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/y86_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : y86_fetch_if
// Purpose  : Fetch-to-decode handshake bundle plus the commit return path
//            from execute/mem.
// Ports    : master = fetch side (drives instruction fields, out_valid)
//            slave  = decode/commit side (drives out_ready, commit_*)
// Revision : 1.0  initial release
// ============================================================================
interface y86_fetch_if;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_valid;
    logic [2:0]  stat;
    logic        commit_valid;
    logic        commit_cnd;
    logic [63:0] commit_valM;

    modport master (
        output out_valid, icode, ifun, rA, rB, valC, valP, instr_valid, stat,
        input  out_ready, commit_valid, commit_cnd, commit_valM
    );

    modport slave (
        input  out_valid, icode, ifun, rA, rB, valC, valP, instr_valid, stat,
        output out_ready, commit_valid, commit_cnd, commit_valM
    );
endinterface
`default_nettype wire

// File: rtl/y86_instr_split.sv
`default_nettype none
// ============================================================================
// Module   : y86_instr_split
// Purpose  : Combinational splitter: turns 10 raw bytes at pc into the
//            instruction fields, valP, legality and status.
// Ports    : raw (10 bytes, byte 0 in [7:0]), pc  -> icode, ifun, rA, rB,
//            valC, valP, instr_valid, stat
// Revision : 1.0  initial release
// ============================================================================
module y86_instr_split
    import y86_pkg::*;
#(
    parameter int IMEM_BYTES = 1024
) (
    input  logic [79:0] raw,
    input  logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic [2:0]  stat
);
    logic [3:0]  w_len;
    logic        w_legal;
    logic        w_in_range;
    logic [64:0] w_last;

    always_comb begin
        icode = raw[7:4];
        ifun  = raw[3:0];
        w_len = instr_len(raw[7:4]);
        rA    = 4'hF;
        rB    = 4'hF;
        valC  = '0;

        // Register byte exists only for the two-/ten-byte forms
        case (icode)
            c_I_RRMOVQ, c_I_IRMOVQ, c_I_RMMOVQ, c_I_MRMOVQ,
            c_I_OPQ, c_I_PUSHQ, c_I_POPQ: begin
                rA = raw[15:12];
                rB = raw[11:8];
            end
            default: ;
        endcase

        case (icode)
            c_I_IRMOVQ, c_I_RMMOVQ, c_I_MRMOVQ: valC = raw[79:16];
            c_I_JXX, c_I_CALL:                  valC = raw[71:8];
            default: ;
        endcase

        case (icode)
            c_I_RRMOVQ, c_I_JXX: w_legal = (ifun <= 4'd6);
            c_I_OPQ:             w_legal = (ifun <= 4'd3);
            default:             w_legal = (icode <= c_I_POPQ) && (ifun == 4'd0);
        endcase

        valP = pc + 64'(w_len);

        // Last byte computed one bit wider so a pc near 2^64 cannot wrap
        // back into range.
        w_last     = {1'b0, pc} + 65'(w_len) - 65'd1;
        w_in_range = (pc < 64'(IMEM_BYTES)) && (w_last < 65'(IMEM_BYTES));

        if (!w_in_range) begin
            stat = c_STAT_ADR;
        end else if (!w_legal) begin
            stat = c_STAT_INS;
        end else begin
            stat = c_STAT_AOK;
        end
        instr_valid = (stat == c_STAT_AOK);
    end
endmodule
`default_nettype wire

// File: rtl/y86_fetch.sv
`default_nettype none
// ============================================================================
// Module   : y86_fetch
// Purpose  : Y86-64 fetch stage: PC, byte-addressed instruction memory,
//            issue handshake to decode and commit-driven next-PC select.
// Ports    : clk, rst_n (async assert, active low)
//            start, prog_we/prog_addr/prog_data  (program load, IDLE only)
//            dec  (y86_fetch_if.master: fields + out_valid/out_ready, commit_*)
//            pc, busy
// Revision : 1.0  initial release
// ============================================================================
module y86_fetch
    import y86_pkg::*;
#(
    parameter int          IMEM_BYTES = 1024,
    parameter int          ADDR_W     = 10,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    y86_fetch_if.master       dec,
    output logic [63:0]       pc,
    output logic              busy
);
    fetch_state_t r_state;
    fetch_state_t w_next;
    logic         w_accept;
    logic         w_commit;

    logic [7:0]   r_imem [IMEM_BYTES];
    logic [79:0]  w_raw;
    logic [ADDR_W-1:0] w_base;

    logic [63:0]  r_pc;
    logic [3:0]   r_icode, r_ifun, r_rA, r_rB;
    logic [63:0]  r_valC, r_valP;
    logic         r_instr_valid;
    logic [2:0]   r_stat;
    logic [63:0]  w_next_pc;

    logic [3:0]   w_icode, w_ifun, w_rA, w_rB;
    logic [63:0]  w_valC, w_valP;
    logic         w_instr_valid;
    logic [2:0]   w_stat;

    // Program load; contents survive reset
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && prog_we) begin
            r_imem[prog_addr] <= prog_data;
        end
    end

    // Byte reads wrap inside the memory; any wrapped read is flagged ADR
    // by the splitter, so the wrapped bytes never reach a valid instruction.
    assign w_base = r_pc[ADDR_W-1:0];
    for (genvar gi = 0; gi < 10; gi++) begin : g_rd
        assign w_raw[8*gi +: 8] = r_imem[w_base + ADDR_W'(gi)];
    end

    y86_instr_split #(.IMEM_BYTES(IMEM_BYTES)) u_split (
        .raw         (w_raw),
        .pc          (r_pc),
        .icode       (w_icode),
        .ifun        (w_ifun),
        .rA          (w_rA),
        .rB          (w_rB),
        .valC        (w_valC),
        .valP        (w_valP),
        .instr_valid (w_instr_valid),
        .stat        (w_stat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_FETCH;
            ST_FETCH: w_next = ST_ISSUE;
            ST_ISSUE: begin
                if (dec.out_ready) begin
                    w_accept = 1'b1;
                    if (r_stat != c_STAT_AOK)    w_next = ST_ERR;
                    else if (r_icode == c_I_HALT) w_next = ST_HALT;
                    else                          w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dec.commit_valid) begin
                    w_commit = 1'b1;
                    w_next   = ST_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_icode)
            c_I_JXX:  w_next_pc = dec.commit_cnd ? r_valC : r_valP;
            c_I_CALL: w_next_pc = r_valC;
            c_I_RET:  w_next_pc = dec.commit_valM;
            default:  w_next_pc = r_valP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_icode       <= '0;
            r_ifun        <= '0;
            r_rA          <= '0;
            r_rB          <= '0;
            r_valC        <= '0;
            r_valP        <= '0;
            r_instr_valid <= 1'b0;
            r_stat        <= c_STAT_AOK;
        end else begin
            if (r_state == ST_FETCH) begin
                r_icode       <= w_icode;
                r_ifun        <= w_ifun;
                r_rA          <= w_rA;
                r_rB          <= w_rB;
                r_valC        <= w_valC;
                r_valP        <= w_valP;
                r_instr_valid <= w_instr_valid;
                r_stat        <= w_stat;
            end
            if (w_accept && w_next == ST_HALT) begin
                r_stat <= c_STAT_HLT;
            end
            if (w_commit) begin
                r_pc <= w_next_pc;
            end
        end
    end

    assign dec.out_valid   = (r_state == ST_ISSUE);
    assign dec.icode       = r_icode;
    assign dec.ifun        = r_ifun;
    assign dec.rA          = r_rA;
    assign dec.rB          = r_rB;
    assign dec.valC        = r_valC;
    assign dec.valP        = r_valP;
    assign dec.instr_valid = r_instr_valid;
    assign dec.stat        = r_stat;
    assign pc              = r_pc;
    assign busy            = !(r_state == ST_IDLE || r_state == ST_HALT || r_state == ST_ERR);
endmodule
`default_nettype wire

// File: doc/y86_fetch.md
Name: y86_fetch

Overview:
- Fetch stage of the Y86-64 datapath, sitting directly upstream of decode.
- Holds the PC and a byte-addressed instruction memory that is loaded before the run starts.
- Splits each instruction into icode/ifun/rA/rB/valC and computes valP.
- Presents each instruction to decode through a valid/ready handshake, then waits for a commit from execute/mem (cnd, valM) before it selects the next PC.

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes.
- ADDR_W, 10, program-load address width; must equal clog2(IMEM_BYTES).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  leave IDLE and begin fetching at the current PC.
- prog_we  in  1  byte write into imem; honoured in IDLE only.
- prog_addr  in  ADDR_W  write byte address.
- prog_data  in  8  write byte.
- out_ready  in  1  decode accepts the presented instruction.
- commit_valid  in  1  1-cycle pulse: the issued instruction has resolved.
- commit_cnd  in  1  branch condition from execute.
- commit_valM  in  64  return address read by mem, used for ret.
- out_valid  out  1  instruction fields are valid.
- icode, ifun, rA, rB  out  4 each  instruction fields.
- valC  out  64  constant word, little-endian.
- valP  out  64  PC + instruction length.
- instr_valid  out  1  0 when the instruction is illegal or out of range.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- pc  out  64  current PC.
- busy  out  1  high in every state except IDLE, HALT and ERR.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = IDLE, pc = RESET_PC, stat = AOK.
  - All fields, valC and valP = 0; out_valid = 0, instr_valid = 0.
  - imem contents are NOT cleared.
- IDLE: prog_we writes imem[prog_addr]. start moves to FETCH. prog_we is ignored in every other state.
- FETCH (1 cycle): read the instruction at pc and register all outputs; next state is ISSUE. Latency from entering FETCH to out_valid=1 is exactly 1 cycle.
- Length by icode:
  - 0, 1, 9 → 1 byte.
  - 2, 6, A, B → 2 bytes.
  - 7, 8 → 9 bytes.
  - 3, 4, 5 → 10 bytes.
- Field extraction:
  - rA/rB come from byte 1 when the length is ≥2 and the icode is not 7/8; otherwise both are 0xF.
  - valC is bytes 2..9 for icodes 3/4/5 and bytes 1..8 for 7/8; otherwise 0.
- Legality: icode > 0xB is illegal. ifun must be ≤6 for icodes 2/7, ≤3 for icode 6, and 0 for every other icode. An illegal instruction gives instr_valid=0 and stat=INS.
- Range: if pc + length − 1 ≥ IMEM_BYTES, or pc ≥ IMEM_BYTES, then instr_valid=0 and stat=ADR. ADR takes priority over INS.
- valP = pc + length, 64-bit wrap.
- ISSUE: out_valid=1 and outputs are held stable until out_ready=1. On that accept edge:
  - INS/ADR → ERR.
  - icode 0 → HALT with stat=HLT.
  - otherwise → WAIT.
  - out_valid drops on the edge after the accept.
- WAIT: idle until commit_valid. On that edge the new pc is:
  - icode 7: commit_cnd ? valC : valP.
  - icode 8: valC.
  - icode 9: commit_valM.
  - otherwise: valP.
  The block then goes to FETCH.
- commit_valid outside WAIT is ignored. commit_valid in the same cycle as the accept is also ignored; the commit must arrive in a later cycle.
- HALT and ERR are terminal. Outputs hold their last values with out_valid=0; only reset exits these states.
- Reset in any state, including mid-WAIT, aborts immediately and returns to IDLE with pc=RESET_PC.
- A start that arrives outside IDLE is ignored.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (HALT..POPQ)
  - stat codes (AOK/HLT/ADR/INS)
  - the state enum (IDLE, FETCH, ISSUE, WAIT, HALT, ERR)
  - a function that returns instruction length from icode.
- One sub-module, y86_instr_split: purely combinational. Takes 10 raw bytes plus pc and produces the fields, valP, instr_valid and stat. The top level holds only the imem, the FSM and the registers.

Test Plan:
- irmovq: load 30 F0 10 00 00 00 00 00 00 00 at 0, start → one cycle later out_valid=1, icode=3, ifun=0, rA=F, rB=0, valC=0x10, valP=10. After accept and commit, pc=10.
- Taken jump: je at 0 with target 0x40 (73 40 00..), commit_cnd=1 → next pc=0x40. Repeat with commit_cnd=0 → next pc=9.
- ret with valM: byte 90 at 0x20, commit_valM=0x100 → pc=0x100. Fetch at 0x100 with IMEM_BYTES=1024 proceeds normally.
- halt and illegal: byte 00 → after accept, stat=2, state HALT, busy=0, and later commits are ignored. Byte C0 → instr_valid=0, stat=4, state ERR.
- Range: irmovq placed at IMEM_BYTES−5 → instr_valid=0, stat=3.
- Backpressure and reset: hold out_ready=0 for 5 cycles → outputs stable throughout. Assert rst_n=0 while in WAIT → out_valid=0 and pc=0 immediately, and imem contents are retained.
